id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register with built-in load-use hazard detection for the 5-stage core.
//   Captures decoded operands and control from ID each cycle and presents them to EX.
//   ex_rs1/ex_rs2 and ex_ctrl feed the EX-side forwarding unit and the EX/MEM register.
//   Inserts bubbles on load-use hazard or branch flush, freezes on memory hold,
//   and counts the load-use bubbles it inserts.
// PARAMETERS
//   XLEN    32  operand/immediate width
//   PC_W    32  program counter width
//   CNT_W   32  load-use bubble counter width
// PORTS
//   clk            in   1      core clock, all state on rising edge
//   rst_n          in   1      synchronous active-low reset
//   hold           in   1      global pipeline freeze (memory stall)
//   flush          in   1      taken-branch/jump flush from EX
//   id_valid       in   1      ID holds a real instruction
//   id_pc          in   PC_W   ID instruction PC
//   id_rs1,id_rs2  in   5      source register indices
//   id_use_rs1     in   1      instruction reads rs1
//   id_use_rs2     in   1      instruction reads rs2
//   id_rd          in   5      destination register index
//   id_rs1_data    in   XLEN   register-file read data, port 1
//   id_rs2_data    in   XLEN   register-file read data, port 2
//   id_imm         in   XLEN   sign-extended immediate
//   id_ctrl        in   10     {regwrite,memread,memwrite,memtoreg,alusrc,branch,aluop[3:0]}
//   load_use_stall out  1      combinational: IF/PC and IF/ID must hold this cycle
//   ex_valid       out  1      EX slot holds a real instruction
//   ex_pc          out  PC_W   registered copy of id_pc
//   ex_rs1,ex_rs2  out  5      registered source indices (to forwarding)
//   ex_rd          out  5      registered destination index
//   ex_rs1_data    out  XLEN   registered read data 1
//   ex_rs2_data    out  XLEN   registered read data 2
//   ex_imm         out  XLEN   registered immediate
//   ex_ctrl        out  10     registered control bundle, same packing as id_ctrl
//   bubble_cnt     out  CNT_W  number of load-use bubbles inserted, saturating
// BEHAVIOUR
//   - Hazard (combinational): haz = ex_valid & ex_ctrl[8] & (ex_rd!=0) & id_valid &
//     ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//     load_use_stall = haz & ~flush. Not gated by hold.
//   - Bubble value: ex_valid=0, ex_ctrl=0, ex_rd=0, ex_rs1=0, ex_rs2=0.
//     Data, pc and imm are don't-care; they are driven to 0.
//   - Register update priority at each rising edge:
//       1. !rst_n           -> all outputs 0, bubble_cnt=0.
//       2. hold             -> every register keeps its value. flush and haz are ignored.
//       3. flush            -> bubble loaded.
//       4. haz              -> bubble loaded; bubble_cnt+1, saturating at all-ones.
//       5. otherwise        -> load all id_* fields; ex_valid=id_valid.
//          If id_valid=0, ex_ctrl/ex_rd/ex_rs1/ex_rs2 load 0.
//   - Latency: 1 cycle, ID to EX. A load-use stall costs exactly one bubble.
//     While EX holds that bubble, haz=0, so the held ID instruction loads on the next edge.
//   - flush and haz in the same cycle: single bubble, stall output 0, counter unchanged.
//   - bubble_cnt changes only in case 4. It holds at 2^CNT_W-1.
//   - Reset asserted mid-stall: the next edge yields the reset state.
//     load_use_stall drops as soon as ex_valid=0.
// TESTING
//   1. Reset: rst_n=0 one edge with random id_* -> all outputs 0, load_use_stall=0.
//   2. Load-use: EX=lw x5 (memread=1, rd=5); ID add x6,x5,x1 (use_rs1=1)
//      -> load_use_stall=1; next edge ex_valid=0, ex_rd=0, bubble_cnt=1;
//      following edge ex_rd=6, ex_rs1=5.
//   3. No false hazard: EX lw rd=0, or ID use_rs2=0 with id_rs2=5 -> load_use_stall=0,
//      instruction loads directly, bubble_cnt unchanged.
//   4. Flush+hazard same cycle: setup as in 2 plus flush=1 -> load_use_stall=0,
//      bubble loaded, bubble_cnt unchanged.
//   5. Hold: hold=1 for 3 edges with changing id_* and flush=1 -> all ex_* and
//      bubble_cnt unchanged; hold=0 -> flush takes effect.
//   6. Saturation: CNT_W=2, force 5 load-use hazards -> bubble_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction from ID, pipeline control inputs,
// and the registered EX-side view plus the hazard stall back to IF/ID.
interface id_ex_stage_if #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   // pipeline control
   logic             hold;
   logic             flush;
   // decoded instruction from ID
   logic             id_valid;
   logic [PC_W-1:0]  id_pc;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [4:0]       id_rd;
   logic [XLEN-1:0]  id_rs1_data;
   logic [XLEN-1:0]  id_rs2_data;
   logic [XLEN-1:0]  id_imm;
   logic [9:0]       id_ctrl;
   // stage outputs
   logic             load_use_stall;
   logic             ex_valid;
   logic [PC_W-1:0]  ex_pc;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic [XLEN-1:0]  ex_rs1_data;
   logic [XLEN-1:0]  ex_rs2_data;
   logic [XLEN-1:0]  ex_imm;
   logic [9:0]       ex_ctrl;
   logic [CNT_W-1:0] bubble_cnt;

   // decode side: drives ID fields and pipeline control, observes EX
   modport master (
      output hold, flush, id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_rs1_data, id_rs2_data, id_imm, id_ctrl,
      input  load_use_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd,
             ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl, bubble_cnt
   );

   // the ID/EX register itself
   modport slave (
      input  hold, flush, id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_rs1_data, id_rs2_data, id_imm, id_ctrl,
      output load_use_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd,
             ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage core with load-use hazard detection.
// A load in EX whose destination is read by the instruction in ID forces one
// bubble into EX while IF/ID hold; a taken-branch flush also loads a bubble;
// a memory hold freezes everything. Load-use bubbles are counted (saturating).
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
);

   // EX-side stage registers
   logic             vld_p1;
   logic [PC_W-1:0]  pc_p1;
   logic [4:0]       rs1_p1;
   logic [4:0]       rs2_p1;
   logic [4:0]       rd_p1;
   logic [XLEN-1:0]  rs1_data_p1;
   logic [XLEN-1:0]  rs2_data_p1;
   logic [XLEN-1:0]  imm_p1;
   logic [9:0]       ctrl_p1;
   logic [CNT_W-1:0] bubble_cnt_q;

   logic             haz;

   // counter increment that sticks at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // load in EX (ctrl bit 8 = memread) writing a register that ID reads
   always_comb begin
      haz = vld_p1 & ctrl_p1[8] & (rd_p1 != 5'd0) & bus.id_valid &
            ((bus.id_use_rs1 & (bus.id_rs1 == rd_p1)) |
             (bus.id_use_rs2 & (bus.id_rs2 == rd_p1)));
   end

   // a flush already kills the ID instruction, so there is nothing to stall for
   assign bus.load_use_stall = haz & ~bus.flush;

   // ID -> EX register: reset, then hold, then flush/hazard bubble, then load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         pc_p1        <= '0;
         rs1_p1       <= '0;
         rs2_p1       <= '0;
         rd_p1        <= '0;
         rs1_data_p1  <= '0;
         rs2_data_p1  <= '0;
         imm_p1       <= '0;
         ctrl_p1      <= '0;
         bubble_cnt_q <= '0;
      end else if (!bus.hold) begin
         if (bus.flush || haz) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            ctrl_p1     <= '0;
            if (!bus.flush) begin
               bubble_cnt_q <= sat_inc(bubble_cnt_q);
            end
         end else begin
            vld_p1      <= bus.id_valid;
            pc_p1       <= bus.id_pc;
            rs1_data_p1 <= bus.id_rs1_data;
            rs2_data_p1 <= bus.id_rs2_data;
            imm_p1      <= bus.id_imm;
            // an empty ID slot must not look like a writer or reader downstream
            rs1_p1      <= bus.id_valid ? bus.id_rs1  : 5'd0;
            rs2_p1      <= bus.id_valid ? bus.id_rs2  : 5'd0;
            rd_p1       <= bus.id_valid ? bus.id_rd   : 5'd0;
            ctrl_p1     <= bus.id_valid ? bus.id_ctrl : 10'd0;
         end
      end
   end

   assign bus.ex_valid    = vld_p1;
   assign bus.ex_pc       = pc_p1;
   assign bus.ex_rs1      = rs1_p1;
   assign bus.ex_rs2      = rs2_p1;
   assign bus.ex_rd       = rd_p1;
   assign bus.ex_rs1_data = rs1_data_p1;
   assign bus.ex_rs2_data = rs2_data_p1;
   assign bus.ex_imm      = imm_p1;
   assign bus.ex_ctrl     = ctrl_p1;
   assign bus.bubble_cnt  = bubble_cnt_q;

endmodule
